// File: rtl/datapath_seq_ctrl_pkg.sv
// Shared types and constants for the register/ALU datapath sequencer.
package datapath_seq_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_MS_W   = 3;

    // Register-file locations selected by W1.
    localparam logic REG_LOC_A = 1'b0;
    localparam logic REG_LOC_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/datapath_seq_ctrl_if.sv
// Request, result and datapath-control signals of the sequencer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The sender holds valid and its payload stable until that
// edge; ready may be raised or lowered freely and never depends on valid.
//
// modport slave  : the sequencer (accepts requests, drives results and
//                  the datapath control pins).
// modport master : the environment (issues requests, consumes results,
//                  returns the datapath ALU output).
interface datapath_seq_ctrl_if
    import datapath_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MS_W   = DEF_MS_W
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [MS_W-1:0]   req_op;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [MS_W-1:0]   res_op;

    logic [DATA_W-1:0] dp_din;
    logic              dp_we;
    logic              dp_w1;
    logic [MS_W-1:0]   dp_ms;
    logic [DATA_W-1:0] dp_alu_out;

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready, dp_alu_out,
        output req_ready, res_valid, res_data, res_op,
               dp_din, dp_we, dp_w1, dp_ms
    );

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready, dp_alu_out,
        input  req_ready, res_valid, res_data, res_op,
               dp_din, dp_we, dp_w1, dp_ms
    );

endinterface

// File: rtl/datapath_seq_ctrl.sv
// Sequencer for the 2-entry register file / ALU datapath: loads A into
// location 0, B into location 1, runs the ALU op and buffers the result
// until the consumer takes it. All outputs come straight from flops.
// Optional macro DATAPATH_SEQ_CTRL_PERF_EN adds a saturating op_cnt
// counter of completed result handshakes.
module datapath_seq_ctrl
    import datapath_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MS_W   = DEF_MS_W
) (
    input  logic                CLK,
    input  logic                RST,
    datapath_seq_ctrl_if.slave  bus,
    output seq_state_t          state_dbg
`ifdef DATAPATH_SEQ_CTRL_PERF_EN
    ,output logic [15:0]        op_cnt
`endif
);

    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [MS_W-1:0]   op_q, op_d;

    logic              req_ready_q, req_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [MS_W-1:0]   res_op_q, res_op_d;

    logic [DATA_W-1:0] dp_din_q, dp_din_d;
    logic              dp_we_q, dp_we_d;
    logic              dp_w1_q, dp_w1_d;
    logic [MS_W-1:0]   dp_ms_q, dp_ms_d;

    logic req_fire;
    logic res_fire;

    assign req_fire = bus.req_valid & req_ready_q;
    assign res_fire = res_valid_q & bus.res_ready;

    // Next state, operand latches, result buffer and the registered
    // datapath controls (decoded from the state being entered).
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;

        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    op_d    = bus.req_op;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: state_d = EXEC;
            EXEC: begin
                res_data_d  = bus.dp_alu_out;
                res_op_d    = op_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_fire) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        dp_we_d     = (state_d == LOAD_A) || (state_d == LOAD_B);
        dp_w1_d     = (state_d == LOAD_B) ? REG_LOC_B : REG_LOC_A;
        dp_din_d    = (state_d == LOAD_A) ? a_d :
                      (state_d == LOAD_B) ? b_d : '0;
        dp_ms_d     = (state_d == IDLE) ? '0 : op_d;
    end

    // State, latches and output registers; reset aborts any operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            dp_din_q    <= '0;
            dp_we_q     <= 1'b0;
            dp_w1_q     <= 1'b0;
            dp_ms_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            dp_din_q    <= dp_din_d;
            dp_we_q     <= dp_we_d;
            dp_w1_q     <= dp_w1_d;
            dp_ms_q     <= dp_ms_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
    assign bus.dp_din    = dp_din_q;
    assign bus.dp_we     = dp_we_q;
    assign bus.dp_w1     = dp_w1_q;
    assign bus.dp_ms     = dp_ms_q;
    assign state_dbg     = state_q;

`ifdef DATAPATH_SEQ_CTRL_PERF_EN
    logic [15:0] op_cnt_q;

    // Count consumed results, sticking at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_cnt_q <= '0;
        end else if (res_fire && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Bench for datapath_seq_ctrl with a behavioural register-file/ALU model.
module tb_datapath_seq_ctrl;
    import datapath_seq_pkg::*;

    localparam int DW = 16;
    localparam int MW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    datapath_seq_ctrl_if #(.DATA_W(DW), .MS_W(MW)) bus ();
    seq_state_t state_dbg;
`ifdef DATAPATH_SEQ_CTRL_PERF_EN
    logic [15:0] op_cnt;
`endif

    datapath_seq_ctrl #(.DATA_W(DW), .MS_W(MW)) dut (
        .CLK       (clk),
        .RST       (RST),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef DATAPATH_SEQ_CTRL_PERF_EN
        ,.op_cnt   (op_cnt)
`endif
    );

    // ---------------- datapath model ----------------
    function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [MW-1:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return b;
        endcase
    endfunction

    logic [DW-1:0] rf0 = '0;
    logic [DW-1:0] rf1 = '0;
    logic          stub_en = 1'b0;

    always @(posedge clk) begin
        if (bus.dp_we) begin
            if (bus.dp_w1) rf1 <= bus.dp_din;
            else           rf0 <= bus.dp_din;
        end
    end

    assign bus.dp_alu_out = stub_en ? 16'h00AB : ref_alu(rf0, rf1, bus.dp_ms);

    // ---------------- checking ----------------
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [MW+DW-1:0] exp_q[$];
    logic             interval_en = 1'b0;
    logic             have_last   = 1'b0;
    int               last_acc    = 0;

    always @(negedge clk) begin
        logic [MW+DW-1:0] e;
        if (!interval_en) have_last = 1'b0;
        if (RST) begin
            exp_q.delete();
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                exp_q.push_back({bus.req_op,
                                 stub_en ? 16'h00AB
                                         : ref_alu(bus.req_a, bus.req_b, bus.req_op)});
                if (interval_en && have_last) check("issue_interval", cyc - last_acc, 5);
                last_acc  = cyc;
                have_last = interval_en;
            end
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_res_data", bus.res_data, e[DW-1:0]);
                    check("sb_res_op", bus.res_op, e[MW+DW-1:DW]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [MW-1:0] op);
        logic acc;
        logic done;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.req_valid = 1'b1;
        bus.res_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.req_ready;
            tick();
        end
        bus.req_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = (state_dbg == IDLE);
        end
        check("run_op_complete", {31'd0, acc & done}, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  n;
        logic acc;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.res_ready = 1'b0;

        repeat (3) tick();
        RST = 1'b0;

        // reset values
        check("rst_state", state_dbg, IDLE);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_op", bus.res_op, 0);
        check("rst_dp_we", bus.dp_we, 0);
        check("rst_dp_w1", bus.dp_w1, 0);
        check("rst_dp_din", bus.dp_din, 0);
        check("rst_dp_ms", bus.dp_ms, 0);

        // idle: nothing moves
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_req_ready", bus.req_ready, 1);
            check("idle_res_valid", bus.res_valid, 0);
            check("idle_dp_we", bus.dp_we, 0);
        end

        // single op with stubbed ALU
        stub_en       = 1'b1;
        bus.req_a     = 16'h0012;
        bus.req_b     = 16'h0034;
        bus.req_op    = 3'b010;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        bus.req_a     = 16'hDEAD;
        bus.req_b     = 16'hBEEF;
        bus.req_op    = 3'b111;
        check("c1_dp_we", bus.dp_we, 1);
        check("c1_dp_w1", bus.dp_w1, 0);
        check("c1_dp_din", bus.dp_din, 16'h0012);
        check("c1_dp_ms", bus.dp_ms, 3'b010);
        check("c1_req_ready", bus.req_ready, 0);
        tick();
        check("c2_dp_we", bus.dp_we, 1);
        check("c2_dp_w1", bus.dp_w1, 1);
        check("c2_dp_din", bus.dp_din, 16'h0034);
        tick();
        check("c3_dp_ms", bus.dp_ms, 3'b010);
        check("c3_dp_we", bus.dp_we, 0);
        check("c3_res_valid", bus.res_valid, 0);
        tick();
        check("c4_res_valid", bus.res_valid, 1);
        check("c4_res_data", bus.res_data, 16'h00AB);
        check("c4_res_op", bus.res_op, 3'b010);
        stub_en = 1'b0;

        // back-pressure with a pending request
        bus.req_a     = 16'h0005;
        bus.req_b     = 16'h0007;
        bus.req_op    = 3'd1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_res_valid", bus.res_valid, 1);
            check("bp_res_data", bus.res_data, 16'h00AB);
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_dp_we", bus.dp_we, 0);
        end
        bus.res_ready = 1'b1;
        tick();
        check("bp_release_state", state_dbg, IDLE);
        check("bp_release_req_ready", bus.req_ready, 1);
        check("bp_release_res_valid", bus.res_valid, 0);
        tick();
        bus.req_valid = 1'b0;
        check("bp_next_accept_state", state_dbg, LOAD_A);
        check("bp_next_dp_din", bus.dp_din, 16'h0005);
        repeat (4) tick();
        check("bp_next_done", state_dbg, IDLE);

        // reset during LOAD_B aborts the op
        bus.req_a     = 16'h1111;
        bus.req_b     = 16'h2222;
        bus.req_op    = 3'd0;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("abort_in_load_b", state_dbg, LOAD_B);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_state", state_dbg, IDLE);
        check("abort_dp_we", bus.dp_we, 0);
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_req_ready", bus.req_ready, 1);
        run_op(16'hFFFF, 16'h0001, 3'd0);
        run_op(16'h00F0, 16'h0FF0, 3'd4);

        // random back-to-back ops
        interval_en   = 1'b1;
        bus.res_ready = 1'b1;
        bus.req_a     = DW'($urandom_range(0, 16'hFFFF));
        bus.req_b     = DW'($urandom_range(0, 16'hFFFF));
        bus.req_op    = MW'($urandom_range(0, 7));
        bus.req_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 1000 && n < 100; c++) begin
            acc = bus.req_ready;
            tick();
            if (acc) begin
                n++;
                bus.req_a  = DW'($urandom_range(0, 16'hFFFF));
                bus.req_b  = DW'($urandom_range(0, 16'hFFFF));
                bus.req_op = MW'($urandom_range(0, 7));
            end
        end
        bus.req_valid = 1'b0;
        check("random_ops_issued", n, 100);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        interval_en = 1'b0;
        check("sb_drained", exp_q.size(), 0);

`ifdef DATAPATH_SEQ_CTRL_PERF_EN
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("perf_rst", op_cnt, 0);
        run_op(16'h0001, 16'h0002, 3'd0);
        run_op(16'h0003, 16'h0004, 3'd2);
        run_op(16'h0005, 16'h0006, 3'd7);
        check("perf_cnt3", op_cnt, 3);
        force dut.op_cnt_q = 16'hFFFE;
        #1;
        release dut.op_cnt_q;
        run_op(16'h0007, 16'h0008, 3'd3);
        run_op(16'h0009, 16'h000A, 3'd5);
        run_op(16'h000B, 16'h000C, 3'd6);
        check("perf_saturate", op_cnt, 16'hFFFF);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
